// File: rtl/aes_result_buffer.sv
// In-order result buffer between the masked AES scalar unit and core writeback; entries are zeroised on pop/flush.
// Optional feature: define AES_RESULT_BYPASS_EN for a zero-latency empty-buffer bypass path.
module aes_result_buffer #(
  parameter int DEPTH      = 2,
  parameter int X_ID_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [31:0]             result_i,
  input  logic [X_ID_WIDTH-1:0]   instr_id_i,
  input  logic                    flush_i,
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic [31:0]             result_data_o,
  output logic [X_ID_WIDTH-1:0]   result_id_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [31:0]           data_q [DEPTH];
  logic [X_ID_WIDTH-1:0] id_q   [DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [PW:0]           count_q;

  logic empty, bypass, push, push_store, pop_store;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high at
  // the rising edge; ready_o never depends on result_ready_i, and flush blocks both sides.
  assign empty      = (count_q == '0);
  assign ready_o    = (count_q != FULL_CNT) && !flush_i;
  assign push       = valid_i && ready_o;
  assign push_store = push && !bypass;
  assign pop_store  = !empty && result_ready_i && !flush_i;
  assign count_o    = count_q;

`ifdef AES_RESULT_BYPASS_EN
  // Empty buffer with a ready consumer: the result goes straight through, never stored.
  assign bypass = empty && valid_i && result_ready_i && !flush_i;

  always_comb begin
    result_valid_o = !empty || bypass;
    result_data_o  = '0;
    result_id_o    = '0;
    if (bypass) begin
      result_data_o = result_i;
      result_id_o   = instr_id_i;
    end else if (!empty) begin
      result_data_o = data_q[rptr_q];
      result_id_o   = id_q[rptr_q];
    end
  end
`else
  assign bypass = 1'b0;

  always_comb begin
    result_valid_o = !empty;
    result_data_o  = '0;
    result_id_o    = '0;
    if (!empty) begin
      result_data_o = data_q[rptr_q];
      result_id_o   = id_q[rptr_q];
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        id_q[i]   <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        id_q[i]   <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      // Push and pop never target the same slot: that needs count 0 or DEPTH.
      if (push_store) begin
        data_q[wptr_q] <= result_i;
        id_q[wptr_q]   <= instr_id_i;
        wptr_q         <= wptr_q + PW'(1);
      end
      if (pop_store) begin
        data_q[rptr_q] <= '0;
        id_q[rptr_q]   <= '0;
        rptr_q         <= rptr_q + PW'(1);
      end
      case ({push_store, pop_store})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_result_buffer.sv
// Directed bench for aes_result_buffer (default build, DEPTH=2): driver tasks feed a scoreboard queue, a monitor checks pops.
module tb_aes_result_buffer;

  localparam int DEPTH = 2;
  localparam int IW    = 4;
  localparam int W     = 32 + IW;

  logic            clk_i = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [31:0]     result_i = '0;
  logic [IW-1:0]   instr_id_i = '0;
  logic            flush_i = 1'b0;
  logic            result_valid_o;
  logic            result_ready_i = 1'b0;
  logic [31:0]     result_data_o;
  logic [IW-1:0]   result_id_o;
  logic [1:0]      count_o;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  int           m_count = 0;

  aes_result_buffer #(.DEPTH(DEPTH), .X_ID_WIDTH(IW)) dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .result_i       (result_i),
    .instr_id_i     (instr_id_i),
    .flush_i        (flush_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_data_o  (result_data_o),
    .result_id_o    (result_id_o),
    .count_o        (count_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid_i = 1'b0; flush_i = 1'b0; result_ready_i = 1'b0;
    result_i = '0; instr_id_i = '0;
    exp_q.delete();
    m_count = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- driver ----------------
  // One clock cycle of stimulus; returns whether the model expects the push to be taken.
  task automatic step(input logic v, input logic [31:0] d, input logic [IW-1:0] id,
                      input logic rr, input logic fl, output logic taken);
    logic m_ready, m_pop;
    chk("count_o", 64'(count_o), 64'(m_count));
    valid_i = v; result_i = d; instr_id_i = id; result_ready_i = rr; flush_i = fl;
    #1;
    m_ready = (m_count != DEPTH) && !fl;
    m_pop   = (m_count != 0) && rr && !fl;
    taken   = v && m_ready;
    chk("ready_o", 64'(ready_o), 64'(m_ready));
    if (fl) begin
      exp_q.delete();
      m_count = 0;
    end else begin
      if (taken) exp_q.push_back({d, id});
      m_count = m_count + int'(taken) - int'(m_pop);
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic idle(input logic rr);
    logic t;
    step(1'b0, '0, '0, rr, 1'b0, t);
  endtask

  task automatic send(input logic [31:0] d, input logic [IW-1:0] id, input logic rr);
    logic t;
    int tries = 0;
    t = 1'b0;
    while (!t && tries < 8) begin
      step(1'b1, d, id, rr, 1'b0, t);
      tries++;
    end
    chk("send_accepted", 64'(t), 64'd1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_val  = '0;

  always @(negedge clk_i) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && result_valid_o)
        chk("hold_stable", 64'({result_data_o, result_id_o}), 64'(prev_val));
      if (result_valid_o && result_ready_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 64'({result_data_o, result_id_o}), 64'd0);
          failures += (({result_data_o, result_id_o}) == '0) ? 1 : 0;
        end else begin
          chk("pop_data", 64'({result_data_o, result_id_o}), 64'(exp_q.pop_front()));
        end
      end
      prev_hold = result_valid_o && !result_ready_i;
      prev_val  = {result_data_o, result_id_o};
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    logic t;
    do_reset();

    // reset state
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_valid", 64'(result_valid_o), 64'd0);
    chk("rst_data", 64'(result_data_o), 64'd0);
    chk("rst_id", 64'(result_id_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);

    // single pass: visible one cycle after push, slot zeroised after pop
    step(1'b1, 32'h63C6A5F2, 4'd3, 1'b1, 1'b0, t);
    chk("sp_valid", 64'(result_valid_o), 64'd1);
    chk("sp_data", 64'(result_data_o), 64'h63C6A5F2);
    chk("sp_id", 64'(result_id_o), 64'd3);
    idle(1'b1);
    chk("sp_zero_data", 64'(dut.data_q[0]), 64'd0);
    chk("sp_zero_id", 64'(dut.id_q[0]), 64'd0);
    chk("sp_empty_valid", 64'(result_valid_o), 64'd0);

    // fill and backpressure
    do_reset();
    step(1'b1, 32'hA0000001, 4'd1, 1'b0, 1'b0, t);
    step(1'b1, 32'hA0000002, 4'd2, 1'b0, 1'b0, t);
    chk("full_count", 64'(count_o), 64'd2);
    chk("full_ready", 64'(ready_o), 64'd0);
    step(1'b1, 32'hA0000003, 4'd3, 1'b0, 1'b0, t);
    chk("full_reject", 64'(t), 64'd0);
    chk("full_head_id", 64'(result_id_o), 64'd1);
    idle(1'b1);
    chk("after_pop_ready", 64'(ready_o), 64'd1);
    idle(1'b1);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // streaming with toggling ready, pointers wrap
    do_reset();
    send(32'h11110000, 4'd0, 1'b1);
    send(32'h22220001, 4'd1, 1'b0);
    send(32'h33330002, 4'd2, 1'b1);
    send(32'h44440003, 4'd3, 1'b1);
    send(32'h55550004, 4'd4, 1'b0);
    send(32'h66660005, 4'd5, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("stream_drained", 64'(exp_q.size()), 64'd0);

    // flush with concurrent push and pop
    do_reset();
    step(1'b1, 32'hB0000001, 4'd1, 1'b0, 1'b0, t);
    step(1'b1, 32'hB0000002, 4'd2, 1'b0, 1'b0, t);
    step(1'b1, 32'hB0000003, 4'd9, 1'b1, 1'b1, t);
    chk("fl_count", 64'(count_o), 64'd0);
    chk("fl_valid", 64'(result_valid_o), 64'd0);
    chk("fl_data", 64'(result_data_o), 64'd0);
    chk("fl_id", 64'(result_id_o), 64'd0);
    chk("fl_mem0", 64'({dut.data_q[0], dut.id_q[0]}), 64'd0);
    chk("fl_mem1", 64'({dut.data_q[1], dut.id_q[1]}), 64'd0);

    // asynchronous reset between edges
    do_reset();
    step(1'b1, 32'hC0FFEE00, 4'd7, 1'b0, 1'b0, t);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(result_valid_o), 64'd0);
    chk("ar_data", 64'(result_data_o), 64'd0);
    chk("ar_id", 64'(result_id_o), 64'd0);
    chk("ar_count", 64'(count_o), 64'd0);
    chk("ar_mem0", 64'(dut.data_q[0]), 64'd0);
    exp_q.delete();
    m_count = 0;
    @(posedge clk_i);
    #1 rst_n = 1'b1;
    chk("ar_ready", 64'(ready_o), 64'd1);
    chk("ar_count_rel", 64'(count_o), 64'd0);

    // zeroisation of a popped all-ones entry
    do_reset();
    step(1'b1, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, t);
    chk("z_stored", 64'({dut.data_q[0], dut.id_q[0]}), 64'hF_FFFF_FFFF);
    idle(1'b1);
    chk("z_data", 64'(dut.data_q[0]), 64'd0);
    chk("z_id", 64'(dut.id_q[0]), 64'd0);
    idle(1'b0);

    chk("final_queue", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
